// File: rtl/test_sequencer.sv
// test_sequencer: walks selected task indices, running each one through control reset, start and a bounded wait
module test_sequencer #(
  parameter int unsigned NUMBER_OF_TASKS = 15,
  parameter int unsigned RST_CYCLES      = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        run,
  input  logic        abort,
  input  logic [31:0] task_mask,
  input  logic [31:0] enabled_tasks,
  input  logic        tasks_done,
  output logic        ctrl_rst,
  output logic        start_tests,
  output logic [31:0] current_task_number,
  output logic        busy,
  output logic        seq_done,
  output logic        aborted,
  output logic [31:0] timeout_mask,
  output logic        result_valid,
  output logic [4:0]  result_task,
  output logic [31:0] result_cycles,
  output logic        result_timeout
);
  typedef enum logic [2:0] {IDLE, SCAN, RESET, START, WAIT, LOG, ABORT} state_t;
  localparam logic [31:0] TASK_BITS = ((32'd1 << (NUMBER_OF_TASKS + 1)) - 32'd1) & ~32'd1;
  localparam logic [5:0]  LAST      = 6'(NUMBER_OF_TASKS);
  localparam logic [31:0] RLOAD     = 32'(RST_CYCLES - 1);
  localparam logic [31:0] TLIM      = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] TCYC      = 32'(TIMEOUT_CYCLES);
  state_t      state;
  logic [31:0] sel, cnt, rcnt;
  logic [5:0]  idx;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state               <= IDLE;
      sel                 <= '0;
      cnt                 <= '0;
      rcnt                <= '0;
      idx                 <= 6'd1;
      ctrl_rst            <= 1'b0;
      start_tests         <= 1'b0;
      current_task_number <= '0;
      busy                <= 1'b0;
      seq_done            <= 1'b0;
      aborted             <= 1'b0;
      timeout_mask        <= '0;
      result_valid        <= 1'b0;
      result_task         <= '0;
      result_cycles       <= '0;
      result_timeout      <= 1'b0;
    end else if (abort && state != IDLE && state != ABORT) begin
      state        <= ABORT;
      rcnt         <= RLOAD;
      ctrl_rst     <= 1'b1;
      start_tests  <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (run) begin
          sel          <= task_mask & enabled_tasks & TASK_BITS;
          seq_done     <= 1'b0;
          aborted      <= 1'b0;
          timeout_mask <= '0;
          idx          <= 6'd1;
          busy         <= 1'b1;
          state        <= SCAN;
        end
        SCAN: if (idx > LAST) begin
          seq_done <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end else if (sel[idx[4:0]]) begin
          state               <= RESET;
          rcnt                <= RLOAD;
          ctrl_rst            <= 1'b1;
          current_task_number <= 32'(idx);
        end else begin
          idx <= idx + 6'd1;
        end
        RESET: if (rcnt == '0) begin
          ctrl_rst    <= 1'b0;
          start_tests <= 1'b1;
          state       <= START;
        end else begin
          rcnt <= rcnt - 32'd1;
        end
        START: begin
          start_tests <= 1'b0;
          cnt         <= '0;
          state       <= WAIT;
        end
        // a done arriving on the limit cycle still counts as done
        WAIT: if (tasks_done || cnt == TLIM) begin
          state          <= LOG;
          result_valid   <= 1'b1;
          result_task    <= idx[4:0];
          result_cycles  <= tasks_done ? cnt : TCYC;
          result_timeout <= !tasks_done;
          if (!tasks_done) timeout_mask[idx[4:0]] <= 1'b1;
        end else begin
          cnt <= cnt + 32'd1;
        end
        LOG: begin
          result_valid <= 1'b0;
          idx          <= idx + 6'd1;
          state        <= SCAN;
        end
        ABORT: if (rcnt == '0) begin
          ctrl_rst <= 1'b0;
          aborted  <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end else begin
          rcnt <= rcnt - 32'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_test_sequencer.sv
// tb_test_sequencer: directed and random sequences checked against a per-task result model
module tb_test_sequencer;
  localparam int TO = 50;
  logic        i_clk = 1'b0, i_rst = 1'b1, run = 1'b0, abort = 1'b0, tasks_done = 1'b1;
  logic [31:0] task_mask = '0, enabled_tasks = '0;
  logic        ctrl_rst, start_tests, busy, seq_done, aborted, result_valid, result_timeout;
  logic [31:0] current_task_number, timeout_mask, result_cycles;
  logic [4:0]  result_task;
  int          n_checks = 0, n_errors = 0, n_start = 0;
  int          rst_runs[$];
  logic [37:0] got[$];
  int          dly[32];

  test_sequencer #(.NUMBER_OF_TASKS(15), .RST_CYCLES(4), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .run(run), .abort(abort), .task_mask(task_mask),
    .enabled_tasks(enabled_tasks), .tasks_done(tasks_done), .ctrl_rst(ctrl_rst),
    .start_tests(start_tests), .current_task_number(current_task_number), .busy(busy),
    .seq_done(seq_done), .aborted(aborted), .timeout_mask(timeout_mask),
    .result_valid(result_valid), .result_task(result_task), .result_cycles(result_cycles),
    .result_timeout(result_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {ctrl_rst, start_tests, busy, seq_done, aborted, result_valid, result_timeout, result_task}, 0);
    check({tag, "_task"}, current_task_number, 0);
    check({tag, "_tmask"}, timeout_mask, 0);
    check({tag, "_cycles"}, result_cycles, 0);
  endtask

  // monitor: ctrl_rst run lengths, start pulses, emitted results
  initial begin
    int run_len;
    run_len = 0;
    forever begin
      @(negedge i_clk);
      if (i_rst) run_len = 0;
      else begin
        if (ctrl_rst) run_len++;
        else if (run_len > 0) begin rst_runs.push_back(run_len); run_len = 0; end
        if (start_tests) n_start++;
        if (result_valid) got.push_back({result_task, result_cycles, result_timeout});
      end
    end
  end

  // responder: raises tasks_done in WAIT cycle dly[task] and leaves it high (stale) until the next WAIT
  initial begin
    int wj;
    wj = -1;
    forever begin
      @(negedge i_clk);
      if (i_rst) wj = -1;
      else if (start_tests) wj = 0;
      else if (wj >= 0) begin
        tasks_done = (wj >= dly[current_task_number[4:0]]);
        wj++;
      end
    end
  end

  task automatic run_seq(input logic [31:0] m, input logic [31:0] e);
    logic [31:0] s, tm;
    logic [37:0] exp_q[$];
    int n0, r0, s0, j;
    s = m & e & 32'h0000_FFFE;
    tm = '0;
    for (int t = 1; t <= 15; t++)
      if (s[t]) begin
        if (dly[t] < TO) exp_q.push_back({5'(t), 32'(dly[t]), 1'b0});
        else begin exp_q.push_back({5'(t), 32'(TO), 1'b1}); tm[t] = 1'b1; end
      end
    n0 = got.size(); r0 = rst_runs.size(); s0 = n_start;
    task_mask = m; enabled_tasks = e; run = 1'b1;
    @(negedge i_clk);
    run = 1'b0;
    check("busy_rise", busy, 1);
    check("seq_done_clear", seq_done, 0);
    check("aborted_clear", aborted, 0);
    j = 0;
    while (busy && j < 5000) begin @(negedge i_clk); j++; end
    check("seq_end", busy, 0);
    @(negedge i_clk);
    check("seq_done", seq_done, 1);
    check("aborted", aborted, 0);
    check("timeout_mask", timeout_mask, tm);
    check("result_count", got.size() - n0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (n0 + i < got.size()) check("result", got[n0 + i], exp_q[i]);
    check("rst_run_count", rst_runs.size() - r0, exp_q.size());
    for (int i = r0; i < rst_runs.size(); i++) check("ctrl_rst_len", rst_runs[i], 4);
    check("start_count", n_start - s0, exp_q.size());
  endtask

  task automatic wait_start();
    int j;
    j = 0;
    while (!start_tests && j < 200) begin @(negedge i_clk); j++; end
    check("start_seen", start_tests, 1);
  endtask

  initial begin
    int n0, r0, s0, j;
    for (int t = 0; t < 32; t++) dly[t] = 99;
    repeat (3) @(negedge i_clk);
    check_all_zero("reset");
    i_rst = 1'b0;
    @(negedge i_clk);
    // two tasks, done after 10 WAIT cycles each
    dly[2] = 10; dly[3] = 10;
    run_seq(32'h0000_0006, 32'h0000_FFFE);
    // stale done from the previous task held through RESET/START, then 7 low WAIT cycles
    dly[1] = 7;
    run_seq(32'h0000_0002, 32'h0000_FFFE);
    // bit 0 ignored, only task 5 enabled
    dly[5] = 3;
    run_seq(32'hFFFF_FFFF, 32'h0000_0021);
    // task 4 never completes
    dly[4] = 99;
    run_seq(32'h0000_0010, 32'h0000_FFFE);
    // done on the timeout limit cycle wins
    dly[6] = TO - 1; dly[7] = TO;
    run_seq(32'h0000_00C0, 32'h0000_FFFE);
    // abort in the third WAIT cycle of task 1
    dly[1] = 99;
    n0 = got.size(); r0 = rst_runs.size();
    task_mask = 32'h2; enabled_tasks = 32'hFFFE; run = 1'b1;
    @(negedge i_clk);
    run = 1'b0;
    wait_start();
    repeat (3) @(negedge i_clk);
    abort = 1'b1;
    @(negedge i_clk);
    abort = 1'b0;
    check("abort_ctrl_rst", ctrl_rst, 1);
    j = 0;
    while (busy && j < 100) begin @(negedge i_clk); j++; end
    @(negedge i_clk);
    check("abort_aborted", aborted, 1);
    check("abort_seq_done", seq_done, 0);
    check("abort_busy", busy, 0);
    check("abort_no_result", got.size() - n0, 0);
    check("abort_rst_runs", rst_runs.size() - r0, 2);
    if (rst_runs.size() > 0) check("abort_rst_len", rst_runs[rst_runs.size() - 1], 4);
    // restart from idx 1
    dly[1] = 5; dly[2] = 3;
    run_seq(32'h0000_0006, 32'h0000_FFFE);
    // abort in IDLE is ignored
    abort = 1'b1;
    @(negedge i_clk);
    abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_flag", aborted, 0);
    // empty selection
    r0 = rst_runs.size(); s0 = n_start;
    task_mask = 32'h0; enabled_tasks = 32'hFFFE; run = 1'b1;
    @(negedge i_clk);
    run = 1'b0;
    j = 0;
    while (!seq_done && j < 100) begin @(negedge i_clk); j++; end
    check("empty_latency", j, 16);
    check("empty_busy", busy, 0);
    check("empty_ctrl_rst", rst_runs.size() - r0, 0);
    check("empty_ctrl_rst_now", ctrl_rst, 0);
    check("empty_start", n_start - s0, 0);
    // i_rst mid-WAIT
    dly[1] = 99;
    task_mask = 32'h2; run = 1'b1;
    @(negedge i_clk);
    run = 1'b0;
    wait_start();
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check_all_zero("midrst");
    i_rst = 1'b0;
    @(negedge i_clk);
    // random sequences
    for (int r = 0; r < 8; r++) begin
      for (int t = 1; t <= 15; t++) dly[t] = $urandom_range(0, TO + 5);
      run_seq($urandom, $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
